fifo_sync_flags: RTL and testbench
==================================

# fifo_sync_flags

Single-clock, parametrised successor to the team's dual-clock UART FIFO, for buffering where producer and consumer share one clock, e.g. UART TX/RX byte queues inside the core clock domain. Adds features the dual-clock FIFO lacks: any depth (not only powers of two), a live fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a compile-time first-word-fall-through read mode. Memory is an internal register array; no CDC logic.

## Interface
- FIFO_WIDTH, 8, data word width in bits (≥1)
- FIFO_DEPTH, 16, number of entries (≥2, any integer)
- FIFO_addr, 4, pointer width; must satisfy 2^FIFO_addr ≥ FIFO_DEPTH
- AF_LEVEL, 12, almost_full asserts when count ≥ AF_LEVEL (1..FIFO_DEPTH)
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..FIFO_DEPTH-1)
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  FIFO_WIDTH  write data
- rd_en  in  1  read request
- err_clr  in  1  synchronous clear of overflow/underflow
- data_out  out  FIFO_WIDTH  read data
- full, empty  out  1  count == FIFO_DEPTH / count == 0
- almost_full, almost_empty  out  1  threshold flags
- count  out  FIFO_addr+1  entries currently stored (0..FIFO_DEPTH)
- overflow, underflow  out  1  sticky error flags

## Operation
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty, both using the flags valid before the edge.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr advances. Accepted read: rd_ptr advances.
- Pointer wrap: pointer == FIFO_DEPTH-1 goes to 0 (explicit compare, not binary rollover).
- count <= count + wr_acc - rd_acc. Both accepted: count unchanged, both pointers advance.
- Full with wr_en && rd_en: only the read is accepted, count decrements. Empty with both: only the write is accepted; the written word is not bypassed to data_out in that cycle.
- All flags decode combinationally from the count register: full, empty, almost_full (count ≥ AF_LEVEL), almost_empty (count ≤ AE_LEVEL).
- overflow set on wr_en && full; underflow set on rd_en && empty. Both cleared by err_clr; a set event in the same cycle as err_clr wins. Rejected accesses never change pointers, count or memory.
- Reset (async, any time, including mid-burst): pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, data_out 0. Memory contents are not reset.

## Timing
- Flags and count update on the same edge that accepts the access, so they are valid the cycle after.
- Standard mode: data_out is registered and loads mem[rd_ptr] on an accepted read. Read latency is 1 cycle; data_out holds otherwise.
- Write-to-empty-deassert latency is 1 cycle. A write-to-read is possible on the next cycle.
- Back-to-back accesses are sustained every cycle, with no bubbles.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. data_out = mem[rd_ptr] combinationally whenever empty == 0, and 0 when empty. rd_en acknowledges/pops the displayed word, and the next word appears the cycle after.
- FIFO_FWFT_EN undefined: standard registered read as described under Timing.
- Flags, count and error behaviour are identical in both modes.

## Test plan
- Reset then fill: assert reset mid-stream after 5 writes. Required: count=0, empty=1, almost_empty=1, data_out=0 immediately (async). Then write 0x01..0x10 at DEPTH=16: full=1 and count=16 after the 16th edge; almost_full first high when count=12.
- Drain order: from full, read 16 times. Standard mode: data_out = 0x01..0x10, each 1 cycle after its rd_en. FWFT mode: 0x01 visible before the first rd_en. After the last read, empty=1 and almost_empty first high at count=4.
- Overflow/underflow: write while full gives overflow=1 and count stays 16. Read while empty gives underflow=1. err_clr for 1 cycle clears both; err_clr coinciding with a new overflow leaves overflow=1.
- Simultaneous access: at count=16 with wr_en=rd_en=1, count becomes 15. At count=0 with both, count becomes 1 and data_out is unchanged. At count=7 with both for 20 cycles, count stays 7 and data order is preserved.
- Non-power-of-two wrap: DEPTH=10, FIFO_addr=4. Perform 25 interleaved write/read pairs. Required: pointers wrap 9→0, no data lost or reordered, full asserts exactly at count=10.

Source files
------------

// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: write/read handshake, status flags and fill count of
// the single-clock FIFO. The master side is the producer/consumer logic and
// the slave side is the FIFO itself. Widths must match the FIFO instance.
interface fifo_sync_flags_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_addr  = 4
);
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  err_clr;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [FIFO_addr:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO of any depth with a live fill count,
// programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. All flags decode from the count register.
// Compile-time option: define FIFO_FWFT_EN for first-word-fall-through
// reads (data_out shows the head word combinationally, rd_en pops it);
// without it data_out is a register loaded on each accepted read.
module fifo_sync_flags #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_addr  = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input logic              clk,
  input logic              reset,
  fifo_sync_flags_if.slave bus
);

  localparam int CW = FIFO_addr + 1;
  localparam logic [CW-1:0]        DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0]        AE_C     = CW'(AE_LEVEL);
  localparam logic [FIFO_addr-1:0] LAST_PTR = FIFO_addr'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_addr-1:0]  wr_ptr;
  logic [FIFO_addr-1:0]  rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Pointers wrap by explicit compare so any depth works, not just 2^n.
  function automatic logic [FIFO_addr-1:0] next_ptr(input logic [FIFO_addr-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Flags decode straight from the registered count.
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Accept decisions use the flags as they stood before the edge.
  assign wr_acc = bus.wr_en && !bus.full;
  assign rd_acc = bus.rd_en && !bus.empty;

  // Storage write; the array is deliberately left out of reset.
  // NOTE: memories carry no reset so they map onto plain RAM/register
  // arrays; the pointers and count already make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  // Pointer and fill-count bookkeeping for accepted accesses.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && bus.full) overflow_q <= 1'b1;
      else if (bus.err_clr)      overflow_q <= 1'b0;
      if (bus.rd_en && bus.empty) underflow_q <= 1'b1;
      else if (bus.err_clr)       underflow_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through as soon as the FIFO is non-empty.
  assign bus.data_out = bus.empty ? '0 : mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] data_out_q;

  // Registered read: load the head word on an accepted read, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       data_out_q <= '0;
    else if (rd_acc) data_out_q <= mem[rd_ptr];
  end

  assign bus.data_out = data_out_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: two FIFO instances (depth 16 and depth 10) share one
// stimulus stream. Each has a queue-based reference model and a compare
// process that checks every output at each falling edge; directed phases
// add hand-computed literal checks on top of random traffic.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int unit,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d.%s actual=%0h required=%0h at %0t", unit, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D  = (g == 0) ? 16 : 10;
    localparam int AF = (g == 0) ? 12 : 8;
    localparam int AE = (g == 0) ? 4 : 2;

    fifo_sync_flags_if #(.FIFO_WIDTH(8), .FIFO_addr(4)) bus ();

    assign bus.wr_en   = wr_en;
    assign bus.rd_en   = rd_en;
    assign bus.err_clr = err_clr;
    assign bus.data_in = data_in;

    fifo_sync_flags #(
      .FIFO_WIDTH(8), .FIFO_DEPTH(D), .FIFO_addr(4),
      .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );

    // Reference model: a queue of stored words plus totals of accepted
    // writes/reads (pointer positions are those totals modulo the depth).
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_unf  = 1'b0;
    int         n_wr   = 0;
    int         n_rd   = 0;

    always @(posedge clk or posedge reset) begin
      bit was_full;
      bit was_empty;
      if (reset) begin
        q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        n_wr   = 0;
        n_rd   = 0;
      end else begin
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (rd_en && !was_empty) begin
          m_dout = q.pop_front();
          n_rd++;
        end
        if (wr_en && !was_full) begin
          q.push_back(data_in);
          n_wr++;
        end
        if (wr_en && was_full) m_ovf = 1'b1;
        else if (err_clr)      m_ovf = 1'b0;
        if (rd_en && was_empty) m_unf = 1'b1;
        else if (err_clr)       m_unf = 1'b0;
      end
    end

    always @(negedge clk) begin
      logic [7:0] exp_d;
`ifdef FIFO_FWFT_EN
      exp_d = (q.size() != 0) ? q[0] : 8'h00;
`else
      exp_d = m_dout;
`endif
      check("count",        g, 32'(bus.count),        q.size());
      check("full",         g, 32'(bus.full),         32'(q.size() == D));
      check("empty",        g, 32'(bus.empty),        32'(q.size() == 0));
      check("almost_full",  g, 32'(bus.almost_full),  32'(q.size() >= AF));
      check("almost_empty", g, 32'(bus.almost_empty), 32'(q.size() <= AE));
      check("overflow",     g, 32'(bus.overflow),     32'(m_ovf));
      check("underflow",    g, 32'(bus.underflow),    32'(m_unf));
      check("data_out",     g, 32'(bus.data_out),     32'(exp_d));
      check("wr_ptr",       g, 32'(dut.wr_ptr),       n_wr % D);
      check("rd_ptr",       g, 32'(dut.rd_ptr),       n_rd % D);
    end
  end

  // Inputs change 1 time unit after the falling edge and are sampled at the
  // following rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    #1;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    err_clr = c;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] saved;
    int         pw;
    int         pr;

    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    #12 reset = 1'b0;

    // Reset mid-stream after five writes; outputs clear asynchronously.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    after_edge();
    check("pre_reset_count", 0, 32'(u[0].bus.count), 5);
    #2;
    reset = 1'b1;
    wr_en = 1'b0;
    #1;
    check("rst_count",        0, 32'(u[0].bus.count),        0);
    check("rst_empty",        0, 32'(u[0].bus.empty),        1);
    check("rst_almost_empty", 0, 32'(u[0].bus.almost_empty), 1);
    check("rst_full",         0, 32'(u[0].bus.full),         0);
    check("rst_data_out",     0, 32'(u[0].bus.data_out),     0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Fill with 0x01..0x10; almost_full first high at count 12.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      after_edge();
      check("fill_count",       0, 32'(u[0].bus.count),       i);
      check("fill_almost_full", 0, 32'(u[0].bus.almost_full), 32'(i >= 12));
    end
    check("fill_full", 0, 32'(u[0].bus.full), 1);
    check("u1_full_at_10", 1, 32'(u[1].bus.full), 1);

    // Write while full.
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    after_edge();
    check("ovf_set",   0, 32'(u[0].bus.overflow), 1);
    check("ovf_count", 0, 32'(u[0].bus.count),    16);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_FWFT_EN
      check("fwft_head", 0, 32'(u[0].bus.data_out), i);
`endif
      step(1'b0, 8'h00, 1'b1, 1'b0);
      after_edge();
`ifndef FIFO_FWFT_EN
      check("drain_data", 0, 32'(u[0].bus.data_out), i);
`endif
      check("drain_almost_empty", 0, 32'(u[0].bus.almost_empty), 32'(16 - i <= 4));
    end
    check("drain_empty", 0, 32'(u[0].bus.empty), 1);

    // Read while empty, then clear both errors.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    after_edge();
    check("unf_set", 0, 32'(u[0].bus.underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    after_edge();
    check("clr_ovf", 0, 32'(u[0].bus.overflow),  0);
    check("clr_unf", 0, 32'(u[0].bus.underflow), 0);

    // Refill, then a new overflow coincides with err_clr and wins.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    after_edge();
    check("ovf_beats_clr", 0, 32'(u[0].bus.overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous access at full: only the read is accepted.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    after_edge();
    check("both_at_full", 0, 32'(u[0].bus.count), 15);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    after_edge();
    check("drained", 0, 32'(u[0].bus.count), 0);

    // Simultaneous access at empty: only the write is accepted.
    saved = u[0].m_dout;
    step(1'b1, 8'h55, 1'b1, 1'b0);
    after_edge();
    check("both_at_empty", 0, 32'(u[0].bus.count), 1);
`ifndef FIFO_FWFT_EN
    check("no_bypass", 0, 32'(u[0].bus.data_out), 32'(saved));
`endif

    // Hold count at 7 with 20 cycles of simultaneous access.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    after_edge();
    check("steady_7", 0, 32'(u[0].bus.count), 7);

    // Depth-10 wrap: 25 write/read pairs from reset, then fill to exactly 10.
    pulse_reset();
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    after_edge();
    check("wrap_wr_ptr", 1, 32'(u[1].dut.wr_ptr), 5);
    check("wrap_rd_ptr", 1, 32'(u[1].dut.rd_ptr), 5);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      after_edge();
      check("wrap_full", 1, 32'(u[1].bus.full), 32'(i == 10));
    end

    // Random traffic with shifting read/write bias and a mid-cycle reset.
    pw = 2;
    pr = 2;
    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 0) begin
        pw = $urandom_range(1, 3);
        pr = 4 - pw;
      end
      step(1'($urandom_range(0, 3) < pw), 8'($urandom),
           1'($urandom_range(0, 3) < pr), 1'($urandom_range(0, 15) == 0));
      if (n == 800) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    after_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
